// File: rtl/apb_reg_bridge.sv
`timescale 1ns/1ps
// apb_reg_bridge
//   APB3 slave that forwards each transfer to a register block over a
//   req/ack handshake. Wait states are inserted until the register side
//   acknowledges. Out-of-range addresses and handshake timeouts are reported
//   on PSLVERR_o. Back-to-back transfers are accepted with no dead cycle.
//
// Ports
//   PCLK_i, PRESET_N_i         clock, asynchronous active-low reset
//   PSEL_i, PENABLE_i          APB select / access phase
//   PADDR_i, PWRITE_i, PWDATA_i  APB address, direction, write data
//   PRDATA_o, PREADY_o, PSLVERR_o  APB read data, completion, error
//   REG_REQ_o, REG_WR_o        register request (held until ack), direction
//   REG_ADDR_o, REG_WDATA_o    register address and write data
//   REG_RDATA_i, REG_ACK_i     register read data, one-cycle acknowledge
module apb_reg_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK_i,
  input  logic                  PRESET_N_i,
  input  logic                  PSEL_i,
  input  logic                  PENABLE_i,
  input  logic [ADDR_WIDTH-1:0] PADDR_i,
  input  logic                  PWRITE_i,
  input  logic [DATA_WIDTH-1:0] PWDATA_i,
  output logic [DATA_WIDTH-1:0] PRDATA_o,
  output logic                  PREADY_o,
  output logic                  PSLVERR_o,
  output logic                  REG_REQ_o,
  output logic                  REG_WR_o,
  output logic [ADDR_WIDTH-1:0] REG_ADDR_o,
  output logic [DATA_WIDTH-1:0] REG_WDATA_o,
  input  logic [DATA_WIDTH-1:0] REG_RDATA_i,
  input  logic                  REG_ACK_i
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             addr_err;

  assign addr_err = ({1'b0, PADDR_i} >= NUM_REGS_W);

  always_ff @(posedge PCLK_i or negedge PRESET_N_i) begin
    if (!PRESET_N_i) begin
      state       <= IDLE;
      cnt         <= '0;
      PRDATA_o    <= '0;
      PREADY_o    <= 1'b0;
      PSLVERR_o   <= 1'b0;
      REG_REQ_o   <= 1'b0;
      REG_WR_o    <= 1'b0;
      REG_ADDR_o  <= '0;
      REG_WDATA_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL_i && !PENABLE_i) begin
            REG_ADDR_o  <= PADDR_i;
            REG_WR_o    <= PWRITE_i;
            REG_WDATA_o <= PWDATA_i;
            cnt         <= '0;
            if (addr_err) begin
              // Address errors complete with zero wait states, no request.
              state     <= ERR;
              PREADY_o  <= 1'b1;
              PSLVERR_o <= 1'b1;
              PRDATA_o  <= '0;
            end else begin
              state     <= REQ;
              REG_REQ_o <= 1'b1;
            end
          end
        end
        REQ: begin
          if (!PSEL_i) begin
            // Master abandoned the transfer: withdraw silently.
            REG_REQ_o <= 1'b0;
            state     <= IDLE;
          end else if (REG_ACK_i) begin
            // Ack takes priority over a coincident timeout.
            REG_REQ_o <= 1'b0;
            if (!REG_WR_o) PRDATA_o <= REG_RDATA_i;
            PREADY_o  <= 1'b1;
            PSLVERR_o <= 1'b0;
            state     <= RESP;
          end else if (cnt == CNT_LAST) begin
            REG_REQ_o <= 1'b0;
            PREADY_o  <= 1'b1;
            PSLVERR_o <= 1'b1;
            PRDATA_o  <= '0;
            state     <= ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP, ERR: begin
          PREADY_o  <= 1'b0;
          PSLVERR_o <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_bridge.sv
`timescale 1ns/1ps
module tb_apb_reg_bridge;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NR = 8;
  localparam int TO = 16;

  logic          PCLK_i = 1'b0;
  logic          PRESET_N_i;
  logic          PSEL_i, PENABLE_i, PWRITE_i;
  logic [AW-1:0] PADDR_i;
  logic [DW-1:0] PWDATA_i;
  logic [DW-1:0] PRDATA_o;
  logic          PREADY_o, PSLVERR_o;
  logic          REG_REQ_o, REG_WR_o;
  logic [AW-1:0] REG_ADDR_o;
  logic [DW-1:0] REG_WDATA_o;
  logic [DW-1:0] REG_RDATA_i;
  logic          REG_ACK_i;

  int tests = 0;
  int fails = 0;

  // Reference model: register file contents and APB read-data register.
  logic [DW-1:0] mem [NR];
  logic [DW-1:0] exp_prdata;

  apb_reg_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK_i     (PCLK_i),
    .PRESET_N_i (PRESET_N_i),
    .PSEL_i     (PSEL_i),
    .PENABLE_i  (PENABLE_i),
    .PADDR_i    (PADDR_i),
    .PWRITE_i   (PWRITE_i),
    .PWDATA_i   (PWDATA_i),
    .PRDATA_o   (PRDATA_o),
    .PREADY_o   (PREADY_o),
    .PSLVERR_o  (PSLVERR_o),
    .REG_REQ_o  (REG_REQ_o),
    .REG_WR_o   (REG_WR_o),
    .REG_ADDR_o (REG_ADDR_o),
    .REG_WDATA_o(REG_WDATA_o),
    .REG_RDATA_i(REG_RDATA_i),
    .REG_ACK_i  (REG_ACK_i)
  );

  always #5 PCLK_i = ~PCLK_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge PCLK_i);
    #1;
  endtask

  // One complete APB transfer acting as both master and register-side
  // responder. ack_delay = index of the REQ cycle carrying REG_ACK_i
  // (>= TO means never). Expectations come from the transfer rules only.
  task automatic do_xfer(input logic [AW-1:0] addr, input logic wr,
                         input logic [DW-1:0] wdata, input int ack_delay,
                         input bit late_ack, input bit keep_sel,
                         input string tag);
    bit valid, exp_err, done, stable_ok;
    int exp_cyc, exp_reqs, cyc, reqs;
    valid = (int'(addr) < NR);
    if (!valid) begin
      exp_cyc = 0; exp_err = 1'b1;
    end else if (ack_delay < TO) begin
      exp_cyc = ack_delay + 1; exp_err = 1'b0;
    end else begin
      exp_cyc = TO; exp_err = 1'b1;
    end
    exp_reqs = valid ? exp_cyc : 0;

    PSEL_i = 1'b1; PENABLE_i = 1'b0; PADDR_i = addr; PWRITE_i = wr;
    PWDATA_i = wdata; REG_ACK_i = 1'b0;
    tick();
    PENABLE_i = 1'b1;

    tests++;
    if (REG_REQ_o !== valid) begin
      fails++;
      $display("FAIL %s req_after_setup: got %b want %b", tag, REG_REQ_o, valid);
    end
    if (valid) begin
      tests++;
      if ({REG_ADDR_o, REG_WR_o, REG_WDATA_o} !== {addr, wr, wdata}) begin
        fails++;
        $display("FAIL %s reg_fields: got a=%h w=%b d=%h want a=%h w=%b d=%h",
                 tag, REG_ADDR_o, REG_WR_o, REG_WDATA_o, addr, wr, wdata);
      end
    end

    cyc = 0; reqs = 0; done = 1'b0; stable_ok = 1'b1;
    while (!done && cyc <= TO + 4) begin
      if (PREADY_o === 1'b1) begin
        done = 1'b1;
      end else begin
        if (REG_REQ_o === 1'b1) begin
          reqs++;
          if (REG_ADDR_o !== addr || REG_WR_o !== wr || REG_WDATA_o !== wdata)
            stable_ok = 1'b0;
        end
        REG_ACK_i   = valid && (cyc == ack_delay);
        REG_RDATA_i = (REG_ACK_i && !wr) ? mem[addr[2:0]] : DW'($urandom);
        tick();
        cyc++;
      end
    end
    // Late ack (while the error response is on the bus) must be ignored.
    REG_ACK_i   = late_ack;
    REG_RDATA_i = DW'($urandom);

    if (valid && !exp_err && wr) mem[addr[2:0]] = wdata;
    if (exp_err) exp_prdata = '0;
    else if (!wr) exp_prdata = mem[addr[2:0]];

    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s pready_bound: no PREADY within %0d cycles", tag, TO + 4);
    end
    tests++;
    if (cyc != exp_cyc) begin
      fails++;
      $display("FAIL %s wait_states: got %0d want %0d", tag, cyc, exp_cyc);
    end
    tests++;
    if (reqs != exp_reqs) begin
      fails++;
      $display("FAIL %s req_cycles: got %0d want %0d", tag, reqs, exp_reqs);
    end
    tests++;
    if (!stable_ok) begin
      fails++;
      $display("FAIL %s req_stable: register fields changed while REG_REQ_o=1 (got 0 want 1)", tag);
    end
    tests++;
    if (PSLVERR_o !== exp_err) begin
      fails++;
      $display("FAIL %s pslverr: got %b want %b", tag, PSLVERR_o, exp_err);
    end
    tests++;
    if (PRDATA_o !== exp_prdata) begin
      fails++;
      $display("FAIL %s prdata: got %h want %h", tag, PRDATA_o, exp_prdata);
    end

    tick();
    REG_ACK_i = 1'b0;
    tests++;
    if ({PREADY_o, PSLVERR_o, REG_REQ_o} !== 3'b000) begin
      fails++;
      $display("FAIL %s after_done: got rdy/err/req=%b want 000",
               tag, {PREADY_o, PSLVERR_o, REG_REQ_o});
    end
    tests++;
    if (PRDATA_o !== exp_prdata) begin
      fails++;
      $display("FAIL %s prdata_hold: got %h want %h", tag, PRDATA_o, exp_prdata);
    end
    if (!keep_sel) begin
      PSEL_i = 1'b0; PENABLE_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    PRESET_N_i = 1'b0; PSEL_i = 1'b0; PENABLE_i = 1'b0; PWRITE_i = 1'b0;
    PADDR_i = '0; PWDATA_i = '0; REG_RDATA_i = '0; REG_ACK_i = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    exp_prdata = '0;
    repeat (3) tick();
    tests++;
    if ({PRDATA_o, PREADY_o, PSLVERR_o, REG_REQ_o, REG_WR_o, REG_ADDR_o, REG_WDATA_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rd=%h rdy=%b err=%b req=%b wr=%b a=%h d=%h want all 0",
               PRDATA_o, PREADY_o, PSLVERR_o, REG_REQ_o, REG_WR_o, REG_ADDR_o, REG_WDATA_o);
    end
    PRESET_N_i = 1'b1;
    tick();
    tests++;
    if ({PREADY_o, REG_REQ_o} !== 2'b00) begin
      fails++;
      $display("FAIL reset_release: got rdy/req=%b want 00", {PREADY_o, REG_REQ_o});
    end
  endtask

  task automatic test_write_fast();
    do_xfer(8'h03, 1'b1, 8'hA5, 0, 1'b0, 1'b0, "write_fast");
    tick();
  endtask

  task automatic test_read_wait();
    do_xfer(8'h05, 1'b0, 8'h00, 2, 1'b0, 1'b0, "read_nodata");
    mem[5] = 8'h3C;  // register block content changed behind the bridge
    do_xfer(8'h05, 1'b0, 8'h00, 2, 1'b0, 1'b0, "read_wait");
    tick();
  endtask

  task automatic test_addr_err();
    do_xfer(8'h08, 1'b1, 8'h77, 0, 1'b0, 1'b0, "addr_err_8");
    do_xfer(8'hFF, 1'b0, 8'h00, 0, 1'b0, 1'b0, "addr_err_ff");
    do_xfer(8'h07, 1'b0, 8'h00, 1, 1'b0, 1'b0, "addr_last_ok");
    tick();
  endtask

  task automatic test_timeout();
    do_xfer(8'h02, 1'b1, 8'h11, TO - 1, 1'b0, 1'b0, "ack_last_cycle");
    do_xfer(8'h02, 1'b0, 8'h00, 0, 1'b0, 1'b0, "read_before_to");
    do_xfer(8'h04, 1'b0, 8'h00, TO + 5, 1'b1, 1'b0, "timeout_read");
    tick();
  endtask

  task automatic test_back_to_back();
    do_xfer(8'h01, 1'b1, 8'h5A, 0, 1'b0, 1'b1, "b2b_write");
    do_xfer(8'h01, 1'b0, 8'h00, 1, 1'b0, 1'b0, "b2b_read");
    tick();
  endtask

  task automatic test_abort();
    PSEL_i = 1'b1; PENABLE_i = 1'b0; PADDR_i = 8'h06; PWRITE_i = 1'b1; PWDATA_i = 8'hEE;
    tick();
    PENABLE_i = 1'b1;
    tick();
    PSEL_i = 1'b0; PENABLE_i = 1'b0;
    tick();
    tests++;
    if ({PREADY_o, REG_REQ_o} !== 2'b00) begin
      fails++;
      $display("FAIL abort_drop: got rdy/req=%b want 00", {PREADY_o, REG_REQ_o});
    end
    tick();
    tests++;
    if ({PREADY_o, PSLVERR_o, REG_REQ_o} !== 3'b000 || PRDATA_o !== exp_prdata) begin
      fails++;
      $display("FAIL abort_quiet: got rdy/err/req=%b rd=%h want 000 rd=%h",
               {PREADY_o, PSLVERR_o, REG_REQ_o}, PRDATA_o, exp_prdata);
    end
    do_xfer(8'h06, 1'b0, 8'h00, 0, 1'b0, 1'b0, "after_abort");
    tick();
  endtask

  task automatic test_reset_mid_req();
    PSEL_i = 1'b1; PENABLE_i = 1'b0; PADDR_i = 8'h02; PWRITE_i = 1'b1; PWDATA_i = 8'h99;
    tick();
    PENABLE_i = 1'b1;
    tick();
    #2 PRESET_N_i = 1'b0;
    #1;
    exp_prdata = '0;
    tests++;
    if ({PRDATA_o, PREADY_o, PSLVERR_o, REG_REQ_o, REG_WR_o, REG_ADDR_o, REG_WDATA_o} !== '0) begin
      fails++;
      $display("FAIL reset_mid_req: got rd=%h rdy=%b err=%b req=%b wr=%b a=%h d=%h want all 0",
               PRDATA_o, PREADY_o, PSLVERR_o, REG_REQ_o, REG_WR_o, REG_ADDR_o, REG_WDATA_o);
    end
    PSEL_i = 1'b0; PENABLE_i = 1'b0;
    tick();
    PRESET_N_i = 1'b1;
    tick();
    do_xfer(8'h02, 1'b0, 8'h00, 1, 1'b0, 1'b0, "after_reset");
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      int d;
      a = AW'($urandom_range(0, NR + 2));
      d = ($urandom_range(0, 9) == 0) ? TO + 3 : int'($urandom_range(0, 4));
      do_xfer(a, 1'($urandom), DW'($urandom), d, 1'($urandom),
              1'($urandom), "random");
    end
    PSEL_i = 1'b0; PENABLE_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_fast();
    test_read_wait();
    test_addr_err();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_reset_mid_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
